// File: rtl/snake_pkg.sv
// Shared definitions for the snake game core: direction codes, FSM states
// and the reversal helper used by the key filter.
package snake_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE = 4'h0;
    localparam dir_t DIR_R    = 4'h1;
    localparam dir_t DIR_D    = 4'h2;
    localparam dir_t DIR_U    = 4'h4;
    localparam dir_t DIR_L    = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_R:   o = DIR_L;
            DIR_L:   o = DIR_R;
            DIR_D:   o = DIR_U;
            DIR_U:   o = DIR_D;
            default: o = DIR_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_step.sv
// Combinational next-head calculation for one game step, with either
// edge wrap-around or an out-of-bounds flag.
module snake_step
    import snake_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    parameter int WRAP   = 1
) (
    input  logic [$clog2(GRID_W)-1:0] cur_x_i,
    input  logic [$clog2(GRID_H)-1:0] cur_y_i,
    input  dir_t                      dir_i,
    output logic [$clog2(GRID_W)-1:0] nxt_x_o,
    output logic [$clog2(GRID_H)-1:0] nxt_y_o,
    output logic                      oob_o
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    always_comb begin
        nxt_x_o = cur_x_i;
        nxt_y_o = cur_y_i;
        oob_o   = 1'b0;
        case (dir_i)
            DIR_R: begin
                if (cur_x_i == X_MAX) begin
                    if (WRAP != 0) nxt_x_o = '0;
                    else           oob_o   = 1'b1;
                end else begin
                    nxt_x_o = cur_x_i + XW'(1);
                end
            end
            DIR_L: begin
                if (cur_x_i == '0) begin
                    if (WRAP != 0) nxt_x_o = X_MAX;
                    else           oob_o   = 1'b1;
                end else begin
                    nxt_x_o = cur_x_i - XW'(1);
                end
            end
            DIR_D: begin
                if (cur_y_i == Y_MAX) begin
                    if (WRAP != 0) nxt_y_o = '0;
                    else           oob_o   = 1'b1;
                end else begin
                    nxt_y_o = cur_y_i + YW'(1);
                end
            end
            DIR_U: begin
                if (cur_y_i == '0) begin
                    if (WRAP != 0) nxt_y_o = Y_MAX;
                    else           oob_o   = 1'b1;
                end else begin
                    nxt_y_o = cur_y_i - YW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game-logic core: key buffering, body shift array, food growth,
// edge handling, self-collision and a registered cell-query port.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   key_edge,
    input  logic                         tick,
    input  logic                         restart,
    input  logic [$clog2(GRID_W)-1:0]    food_x,
    input  logic [$clog2(GRID_H)-1:0]    food_y,
    input  logic [$clog2(GRID_W)-1:0]    q_x,
    input  logic [$clog2(GRID_H)-1:0]    q_y,
    output logic                         q_hit,
    output logic                         q_head,
    output logic [$clog2(GRID_W)-1:0]    head_x,
    output logic [$clog2(GRID_H)-1:0]    head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         ate,
    output logic                         dead
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    state_e         state_q, state_d;
    dir_t           dir_q, dir_d;
    dir_t           pend_q, pend_d;
    logic [LW-1:0]  len_q, len_d;
    logic           ate_q, ate_d;
    logic           hit_q, hit_d;
    logic           qhead_q, qhead_d;
    logic [XW-1:0]  seg_x_q [MAX_LEN];
    logic [XW-1:0]  seg_x_d [MAX_LEN];
    logic [YW-1:0]  seg_y_q [MAX_LEN];
    logic [YW-1:0]  seg_y_d [MAX_LEN];

    dir_t           key_dir;
    logic           key_ok;
    dir_t           step_dir;
    logic [XW-1:0]  nxt_x;
    logic [YW-1:0]  nxt_y;
    logic           oob;
    logic           grow;
    logic [LW-1:0]  coll_lim;
    logic           collide;

    // Highest-priority key wins (R > D > L > U); only that one is tested for reversal.
    always_comb begin
        key_dir = DIR_NONE;
        if      (key_edge[3]) key_dir = DIR_R;
        else if (key_edge[2]) key_dir = DIR_D;
        else if (key_edge[0]) key_dir = DIR_L;
        else if (key_edge[1]) key_dir = DIR_U;
    end

    assign key_ok   = (key_dir != DIR_NONE) && (key_dir != dir_opposite(dir_q));
    assign step_dir = key_ok ? key_dir : pend_q;

    snake_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .WRAP   (WRAP)
    ) u_step (
        .cur_x_i (seg_x_q[0]),
        .cur_y_i (seg_y_q[0]),
        .dir_i   (step_dir),
        .nxt_x_o (nxt_x),
        .nxt_y_o (nxt_y),
        .oob_o   (oob)
    );

    assign grow = (nxt_x == food_x) && (nxt_y == food_y);

    // Without growth the tail cell is vacated in the same step, so it is excluded.
    always_comb begin
        coll_lim = grow ? len_q : len_q - LW'(1);
        collide  = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < coll_lim) && (seg_x_q[i] == nxt_x) && (seg_y_q[i] == nxt_y))
                collide = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        len_d   = len_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        ate_d   = 1'b0;
        hit_d   = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y))
                hit_d = 1'b1;
        end
        qhead_d = (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);

        if (restart) begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            pend_d  = DIR_NONE;
            len_d   = LW'(INIT_LEN);
            hit_d   = 1'b0;
            qhead_d = 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = XW'(GRID_W / 2 - i);
                seg_y_d[i] = YW'(GRID_H / 2);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_ok) begin
                        pend_d  = key_dir;
                        dir_d   = key_dir;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (key_ok) pend_d = key_dir;
                    if (tick) begin
                        dir_d  = step_dir;
                        pend_d = step_dir;
                        if (oob || collide) begin
                            state_d = ST_DEAD;
                        end else begin
                            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                                seg_x_d[i] = seg_x_q[i-1];
                                seg_y_d[i] = seg_y_q[i-1];
                            end
                            seg_x_d[0] = nxt_x;
                            seg_y_d[0] = nxt_y;
                            ate_d      = grow;
                            if (grow && (len_q != LW'(MAX_LEN)))
                                len_d = len_q + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            pend_q  <= DIR_NONE;
            len_q   <= LW'(INIT_LEN);
            ate_q   <= 1'b0;
            hit_q   <= 1'b0;
            qhead_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= XW'(GRID_W / 2 - i);
                seg_y_q[i] <= YW'(GRID_H / 2);
            end
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            ate_q   <= ate_d;
            hit_q   <= hit_d;
            qhead_q <= qhead_d;
            seg_x_q <= seg_x_d;
            seg_y_q <= seg_y_d;
        end
    end

    assign head_x = seg_x_q[0];
    assign head_y = seg_y_q[0];
    assign length = len_q;
    assign ate    = ate_q;
    assign dead   = (state_q == ST_DEAD);
    assign q_hit  = hit_q;
    assign q_head = qhead_q;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed vector table, hand-written
// corner sequences and random play against a queue-based game model.
module tb_snake_engine;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 16;
    localparam int IL = 3;
    localparam int XW = $clog2(GW);
    localparam int YW = $clog2(GH);
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    key_edge;
    logic          tick;
    logic          restart;
    logic [XW-1:0] food_x, q_x;
    logic [YW-1:0] food_y, q_y;

    logic          q_hit, q_head, ate, dead;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] length;

    logic          nw_q_hit, nw_q_head, nw_ate, nw_dead;
    logic [XW-1:0] nw_head_x;
    logic [YW-1:0] nw_head_y;
    logic [LW-1:0] nw_length;

    always #5 clk = ~clk;

    snake_engine #(
        .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(1)
    ) dut (
        .clk(clk), .rst(rst), .key_edge(key_edge), .tick(tick), .restart(restart),
        .food_x(food_x), .food_y(food_y), .q_x(q_x), .q_y(q_y),
        .q_hit(q_hit), .q_head(q_head), .head_x(head_x), .head_y(head_y),
        .length(length), .ate(ate), .dead(dead)
    );

    snake_engine #(
        .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(0)
    ) dut_nw (
        .clk(clk), .rst(rst), .key_edge(key_edge), .tick(tick), .restart(restart),
        .food_x(food_x), .food_y(food_y), .q_x(q_x), .q_y(q_y),
        .q_hit(nw_q_hit), .q_head(nw_q_head), .head_x(nw_head_x), .head_y(nw_head_y),
        .length(nw_length), .ate(nw_ate), .dead(nw_dead)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: body is a queue of live cells, head first; direction as (dx,dy).
    int m_state;            // 0 idle, 1 running, 2 dead
    int m_dx, m_dy, m_px, m_py;
    int m_bx[$], m_by[$];
    bit m_ate, m_hit, m_qhead;

    task automatic model_reset();
        m_state = 0;
        m_dx = 0; m_dy = 0; m_px = 0; m_py = 0;
        m_bx.delete(); m_by.delete();
        for (int i = 0; i < IL; i++) begin
            m_bx.push_back(GW / 2 - i);
            m_by.push_back(GH / 2);
        end
        m_ate = 0; m_hit = 0; m_qhead = 0;
    endtask

    task automatic model_edge();
        int  kx, ky, nx, ny, limit;
        bit  have, acc, grow, crash;
        kx = 0; ky = 0; have = 1;
        if      (key_edge[3]) kx = 1;
        else if (key_edge[2]) ky = 1;
        else if (key_edge[0]) kx = -1;
        else if (key_edge[1]) ky = -1;
        else                  have = 0;
        acc = have && !(kx == -m_dx && ky == -m_dy);

        m_hit = 0;
        foreach (m_bx[i]) if (m_bx[i] == int'(q_x) && m_by[i] == int'(q_y)) m_hit = 1;
        m_qhead = (m_bx[0] == int'(q_x)) && (m_by[0] == int'(q_y));
        m_ate = 0;

        if (restart) begin
            model_reset();
            return;
        end
        if (m_state == 0) begin
            if (acc) begin
                m_dx = kx; m_dy = ky; m_px = kx; m_py = ky; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (acc) begin m_px = kx; m_py = ky; end
            if (tick) begin
                m_dx = m_px; m_dy = m_py;
                nx = (m_bx[0] + m_dx + GW) % GW;
                ny = (m_by[0] + m_dy + GH) % GH;
                grow  = (nx == int'(food_x)) && (ny == int'(food_y));
                limit = grow ? m_bx.size() : m_bx.size() - 1;
                crash = 0;
                for (int i = 0; i < limit; i++)
                    if (m_bx[i] == nx && m_by[i] == ny) crash = 1;
                if (crash) begin
                    m_state = 2;
                end else begin
                    m_bx.push_front(nx); m_by.push_front(ny);
                    if (!grow || m_bx.size() > ML) begin
                        void'(m_bx.pop_back()); void'(m_by.pop_back());
                    end
                    m_ate = grow;
                end
            end
        end
    endtask

    task automatic check_model();
        check("mdl_head_x", head_x, m_bx[0]);
        check("mdl_head_y", head_y, m_by[0]);
        check("mdl_length", length, m_bx.size());
        check("mdl_ate",    ate,    m_ate);
        check("mdl_dead",   dead,   m_state == 2);
        check("mdl_q_hit",  q_hit,  m_hit);
        check("mdl_q_head", q_head, m_qhead);
    endtask

    // One clock: inputs held across the edge, model advanced, outputs sampled 1ns later.
    task automatic cycle(input logic [3:0] k, input bit t, input bit r);
        key_edge = k; tick = t; restart = r;
        @(posedge clk);
        model_edge();
        #1;
        key_edge = '0; tick = 1'b0; restart = 1'b0;
        check_model();
    endtask

    task automatic set_food(input int x, input int y);
        food_x = XW'(x); food_y = YW'(y);
    endtask

    task automatic set_q(input int x, input int y);
        q_x = XW'(x); q_y = YW'(y);
    endtask

    typedef struct {
        logic [3:0] k;
        bit         t, r;
        int         qx, qy, hx, hy, len;
        bit         ate, dead, hit, qh;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input logic [3:0] k, input bit t, input bit r,
                           input int qx, input int qy, input int hx, input int hy,
                           input int len, input bit a, input bit d, input bit h, input bit qh);
        vec_t v;
        v.k = k; v.t = t; v.r = r; v.qx = qx; v.qy = qy; v.hx = hx; v.hy = hy;
        v.len = len; v.ate = a; v.dead = d; v.hit = h; v.qh = qh;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] k;
        bit         t, r;
        int         sel, d, idx;

        rst = 1'b1; key_edge = '0; tick = 1'b0; restart = 1'b0;
        set_food(0, 0); set_q(0, 0);
        model_reset();
        #12;
        check("rst_head_x", head_x, 16);
        check("rst_head_y", head_y, 12);
        check("rst_length", length, 3);
        check("rst_ate",    ate,    0);
        check("rst_dead",   dead,   0);
        check("rst_q_hit",  q_hit,  0);
        check("rst_q_head", q_head, 0);
        @(negedge clk);
        rst = 1'b0;

        //       key     t  r  qx  qy  hx  hy len ate dead hit qh
        add_vec(4'b0000, 0, 1, 15, 12, 16, 12, 3, 0, 0, 0, 0);
        add_vec(4'b0000, 1, 0, 15, 12, 16, 12, 3, 0, 0, 1, 0);
        add_vec(4'b1000, 0, 0, 16, 12, 16, 12, 3, 0, 0, 1, 1);
        add_vec(4'b0000, 1, 0,  0,  0, 17, 12, 3, 0, 0, 0, 0);
        add_vec(4'b0000, 1, 0, 14, 12, 18, 12, 3, 0, 0, 0, 0);
        add_vec(4'b0000, 1, 0, 16, 12, 19, 12, 3, 0, 0, 1, 0);
        add_vec(4'b0001, 0, 0, 17, 12, 19, 12, 3, 0, 0, 1, 0);
        add_vec(4'b0000, 1, 0, 19, 12, 20, 12, 3, 0, 0, 1, 1);
        add_vec(4'b0100, 0, 0,  0,  0, 20, 12, 3, 0, 0, 0, 0);
        add_vec(4'b0001, 0, 0,  0,  0, 20, 12, 3, 0, 0, 0, 0);
        add_vec(4'b0000, 1, 0,  0,  0, 20, 13, 3, 0, 0, 0, 0);
        add_vec(4'b0000, 1, 0,  0,  0, 20, 14, 3, 0, 0, 0, 0);
        add_vec(4'b1111, 1, 0,  0,  0, 21, 14, 3, 0, 0, 0, 0);
        add_vec(4'b0101, 1, 0,  0,  0, 21, 15, 3, 0, 0, 0, 0);
        add_vec(4'b0010, 1, 0,  0,  0, 21, 16, 3, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            set_q(tbl[i].qx, tbl[i].qy);
            cycle(tbl[i].k, tbl[i].t, tbl[i].r);
            check($sformatf("vec%0d_head_x", i), head_x, tbl[i].hx);
            check($sformatf("vec%0d_head_y", i), head_y, tbl[i].hy);
            check($sformatf("vec%0d_length", i), length, tbl[i].len);
            check($sformatf("vec%0d_ate", i),    ate,    tbl[i].ate);
            check($sformatf("vec%0d_dead", i),   dead,   tbl[i].dead);
            check($sformatf("vec%0d_q_hit", i),  q_hit,  tbl[i].hit);
            check($sformatf("vec%0d_q_head", i), q_head, tbl[i].qh);
        end

        // Growth to capacity, then one saturated eat.
        set_food(0, 0); set_q(0, 0);
        cycle(4'b0000, 0, 1);
        cycle(4'b1000, 0, 0);
        for (int n = 0; n < 14; n++) begin
            set_food(17 + n, 12);
            cycle(4'b0000, 1, 0);
            check("grow_ate", ate, 1);
            check("grow_length", length, (IL + n + 1 > ML) ? ML : IL + n + 1);
            set_food(0, 0);
            cycle(4'b0000, 0, 0);
            check("grow_ate_pulse", ate, 0);
        end

        // Length 5, then steer D, L, U into the body with food on the hit cell.
        cycle(4'b0000, 0, 1);
        cycle(4'b1000, 0, 0);
        set_food(17, 12); cycle(4'b0000, 1, 0);
        set_food(18, 12); cycle(4'b0000, 1, 0);
        check("coll_len5", length, 5);
        set_food(0, 0);
        cycle(4'b0100, 1, 0);
        cycle(4'b0001, 1, 0);
        check("coll_pre_head_x", head_x, 17);
        check("coll_pre_head_y", head_y, 13);
        set_food(17, 12);
        cycle(4'b0010, 1, 0);
        check("coll_dead", dead, 1);
        check("coll_ate_suppressed", ate, 0);
        check("coll_head_x", head_x, 17);
        check("coll_head_y", head_y, 13);
        check("coll_length", length, 5);
        set_food(0, 0);
        cycle(4'b1000, 1, 0);
        cycle(4'b0100, 1, 0);
        check("dead_hold", dead, 1);
        check("dead_head_x", head_x, 17);
        check("dead_head_y", head_y, 13);
        cycle(4'b0000, 1, 1);
        check("restart_dead", dead, 0);
        check("restart_head_x", head_x, 16);
        check("restart_head_y", head_y, 12);
        check("restart_length", length, 3);
        cycle(4'b0000, 1, 0);
        check("idle_tick_head_x", head_x, 16);

        // Right edge: wrap on the main instance, death on the no-wrap instance.
        cycle(4'b0000, 0, 1);
        cycle(4'b1000, 0, 0);
        for (int n = 0; n < 15; n++) cycle(4'b0000, 1, 0);
        check("edge_head_x", head_x, 31);
        check("edge_nw_head_x", nw_head_x, 31);
        check("edge_nw_dead_pre", nw_dead, 0);
        cycle(4'b0000, 1, 0);
        check("wrap_head_x", head_x, 0);
        check("wrap_dead", dead, 0);
        check("nowrap_dead", nw_dead, 1);
        check("nowrap_head_x", nw_head_x, 31);
        check("nowrap_head_y", nw_head_y, 12);
        check("nowrap_length", nw_length, 3);

        // Random play.
        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 9);
            k = '0;
            if (sel < 3) k = 4'b0001 << $urandom_range(0, 3);
            t = ($urandom_range(0, 2) == 0);
            r = (m_state == 2 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom_range(0, 3);
                case (d)
                    0: set_food((m_bx[0] + 1) % GW, m_by[0]);
                    1: set_food((m_bx[0] + GW - 1) % GW, m_by[0]);
                    2: set_food(m_bx[0], (m_by[0] + 1) % GH);
                    default: set_food(m_bx[0], (m_by[0] + GH - 1) % GH);
                endcase
            end else begin
                set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, m_bx.size() - 1);
                set_q(m_bx[idx], m_by[idx]);
            end else begin
                set_q($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
            end
            cycle(k, t, r);
        end

        // Asynchronous reset in the middle of a step.
        cycle(4'b0000, 0, 1);
        cycle(4'b1000, 0, 0);
        cycle(4'b0000, 1, 0);
        set_q(17, 12);
        tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_head_x", head_x, 16);
        check("arst_head_y", head_y, 12);
        check("arst_length", length, 3);
        check("arst_dead", dead, 0);
        check("arst_ate", ate, 0);
        check("arst_q_hit", q_hit, 0);
        check("arst_q_head", q_head, 0);
        @(negedge clk);
        rst = 1'b0; tick = 1'b0;
        model_reset();
        cycle(4'b0000, 1, 0);
        check("arst_idle_head_x", head_x, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised game-logic core for the VGA snake game: turns debounced key edges into a buffered direction, advances a multi-segment body on each game tick, and handles food growth, wrap-around or wall death, and self-collision. It sits between `key_filter` and `image_renderer`. It also gives the renderer a pixel-cell query port, so the renderer does not need access to the body array.

## Interface
- `GRID_W`, default 32: playfield width in cells.
- `GRID_H`, default 24: playfield height in cells.
- `MAX_LEN`, default 16: body segment capacity.
- `INIT_LEN`, default 3: length after reset or restart, 1..`MAX_LEN`.
- `WRAP`, default 1: 1 = edges wrap; 0 = leaving the grid kills.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_edge`  in  4  one-cycle key pulses: [3] right, [2] down, [1] up, [0] left.
- `tick`  in  1  one-cycle game-step strobe, synchronous to `clk`.
- `restart`  in  1  one-cycle pulse; reinitialises the game without `rst`.
- `food_x` / `food_y`  in  XW / YW  food cell. XW = $clog2(`GRID_W`), YW = $clog2(`GRID_H`).
- `q_x` / `q_y`  in  XW / YW  cell being queried by the renderer.
- `q_hit`  out  1  queried cell is occupied by a live segment (registered).
- `q_head`  out  1  queried cell is the head (registered).
- `head_x` / `head_y`  out  XW / YW  current head cell.
- `length`  out  LW  live segment count. LW = $clog2(`MAX_LEN`+1).
- `ate`  out  1  one-cycle pulse when the head lands on food.
- `dead`  out  1  high while the game is in the DEAD state.

## Operation
- Direction encoding (one-hot): 4'h1 R, 4'h2 D, 4'h4 U, 4'h8 L. 4'h0 = stationary.
- Key priority within a single cycle: R > D > L > U.
- A key is rejected if it is the reverse of the committed direction `dir`. The check is not made against `pend`, so two keys between ticks cannot produce a reversal.
- An accepted key writes `pend`. On a tick in RUN, `dir <= pend`.
- FSM states:
  - IDLE: the first accepted key sets `pend` and `dir` and moves to RUN. Ticks in IDLE are ignored.
  - RUN: each tick computes the new head from `dir`.
  - DEAD: ignores ticks and keys.
- `restart` from any state reinitialises to IDLE.
- Step arithmetic: R is x+1, L is x-1, D is y+1, U is y-1. Screen coordinates apply: y=0 is the top row.
- Edges with `WRAP`=1:
  - x=`GRID_W`-1 moving R goes to 0; x=0 moving L goes to `GRID_W`-1.
  - The same rule applies to y.
- Edges with `WRAP`=0: any out-of-range step goes to DEAD. Body, head and length do not change.
- Body is a shift array `seg[0..MAX_LEN-1]`, with `seg[0]` the head. On a step, `seg[i] <= seg[i-1]` and `seg[0] <=` new head. Entries at index >= `length` are don't-care.
- Growth: the new head equals food, so `ate` pulses. `length` increments, saturating at `MAX_LEN`; `ate` still pulses when saturated.
- Self-collision: the new head matches `seg[i]` for i < `length`-1. When growing, the range is i < `length` instead. A hit goes to DEAD with no body update, and `ate` is suppressed.
- Query: `q_hit` = OR over i < `length` of (`seg[i]` == q). `q_head` = (`seg[0]` == q).
- Reset/restart values:
  - Head at (`GRID_W`/2, `GRID_H`/2); `seg[i]` = (`GRID_W`/2 - i, `GRID_H`/2).
  - `length` = `INIT_LEN`, `dir` = `pend` = 0, state IDLE.
  - `ate` = `dead` = `q_hit` = `q_head` = 0.

## Timing
- Tick to update: head, body, `length`, `ate` and `dead` update on the clock edge that samples `tick`, and are valid in the next cycle.
- Same-cycle key and tick: the key passes the reversal check against the old `dir` and is used for that step.
- `restart` together with a tick: `restart` wins.
- `rst` mid-step: all state returns immediately to the reset values.
- Query latency: exactly 1 `clk` cycle from `q_x`/`q_y` to `q_hit`/`q_head`.
- The renderer presents pixel-cell coordinates one cycle early.

## Structure
- `snake_pkg` holds:
  - direction constants DIR_R/D/U/L/NONE;
  - the state enum IDLE/RUN/DEAD;
  - the opposite-direction function.
- One sub-module, `snake_step`: combinational next-head calculation plus out-of-bounds flag, parametrised by `GRID_W`, `GRID_H` and `WRAP`.
- The collision and query comparator arrays stay in `snake_engine`.

## Test plan
- Reset, then key R, then 3 ticks (defaults):
  - head goes (16,12) → (17,12) → (18,12) → (19,12);
  - `length`=3, `seg[2]`=(17,12).
- Moving R, press L, then tick: L is rejected and the head moves to x+1. Pressing D then L between ticks gives D only.
- `WRAP`=1: head at x=31 moving R, tick gives x=0. `WRAP`=0: same case gives `dead`=1 and the head stays at x=31.
- Food at the next head cell, tick:
  - `ate` is high for 1 cycle and `length` goes 3→4;
  - repeat until `length`=`MAX_LEN`; a further eat pulses `ate` with `length` held at 16.
- Length 5, steering R, D, L, U into the body: `dead`=1, further ticks and keys have no effect, and `restart` returns to IDLE with the reset values.
- Query: `q` = (15,12) after reset gives `q_hit`=1, `q_head`=0 one cycle later. `q` = (16,12) gives `q_head`=1. `q` = (0,0) gives 0.
